// File: rtl/counter_bcd_display_if.sv
// counter_bcd_display_if
//   Bundles the counter value input and the converter/display outputs of
//   counter_bcd_display.
//   master : side that supplies counter_in and observes the results
//   slave  : the converter itself
//   Signals:
//     counter_in  8-bit unsigned value from the counter stage
//     busy        high while a conversion is in progress
//     done        one-cycle pulse when bcd_out has just been updated
//     bcd_valid   high once the first conversion after reset has completed
//     bcd_out     {hundreds, tens, ones} BCD nibbles
//     an          one-hot digit select, bit0 = ones, bit2 = hundreds
//     seg         segments {g,f,e,d,c,b,a}, active-high
interface counter_bcd_display_if;
  logic [7:0]  counter_in;
  logic        busy;
  logic        done;
  logic        bcd_valid;
  logic [11:0] bcd_out;
  logic [2:0]  an;
  logic [6:0]  seg;

  modport master (
    output counter_in,
    input  busy, done, bcd_valid, bcd_out, an, seg
  );

  modport slave (
    input  counter_in,
    output busy, done, bcd_valid, bcd_out, an, seg
  );
endinterface

// File: rtl/counter_bcd_display.sv
// counter_bcd_display
//   Converts the 8-bit counter value to 3-digit BCD with a sequential
//   double-dabble engine (one shift per clock) and drives a time-multiplexed
//   3-digit 7-segment display with leading-zero blanking. A new conversion
//   starts automatically whenever counter_in differs from the last value
//   converted; changes that arrive while busy are picked up afterwards.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  counter_bcd_display_if.slave (counter_in in; busy, done,
//          bcd_valid, bcd_out, an, seg out)
//   Parameter:
//     SCAN_DIV  clock cycles each digit stays lit before advancing (>= 2)
module counter_bcd_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_bcd_display_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;

  logic [7:0]  sreg_q, sreg_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  last_val_q, last_val_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic [11:0] bcd_out_q, bcd_out_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        start;
  logic [7:0]  adj_lo;

  assign start = pending_q || (bus.counter_in != last_val_q);

  // Add-3 correction for the ones and tens nibbles. The hundreds nibble never
  // exceeds 2 for an 8-bit input, so it never needs correcting.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
      assign adj_lo[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                 acc_q[gi*4 +: 4] + 4'd3 : acc_q[gi*4 +: 4];
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sreg_d      = sreg_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    last_val_d  = last_val_q;
    pending_d   = pending_q;
    busy_d      = busy_q;
    bcd_valid_d = bcd_valid_q;
    bcd_out_d   = bcd_out_q;
    done_d      = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d     = bus.counter_in;
          last_val_d = bus.counter_in;
          pending_d  = 1'b0;
          acc_d      = 12'h000;
          bit_cnt_d  = 3'd0;
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        // {acc, sreg} <<= 1 after correction
        acc_d     = {acc_q[10:8], adj_lo, sreg_q[7]};
        sreg_d    = {sreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      DONE: begin
        bcd_out_d   = acc_q;
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q      <= 8'h00;
      acc_q       <= 12'h000;
      bit_cnt_q   <= 3'd0;
      last_val_q  <= 8'h00;
      pending_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
      bcd_out_q   <= 12'h000;
    end else begin
      sreg_q      <= sreg_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      last_val_q  <= last_val_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bcd_valid_q <= bcd_valid_d;
      bcd_out_q   <= bcd_out_d;
    end
  end

  // ------------------------------------------------------------ scanner
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  always_comb begin
    logic [3:0] nib;
    logic       blank;
    nib   = 4'h0;
    blank = 1'b0;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end
    case (idx_q)
      2'd1: begin
        nib   = bcd_out_q[7:4];
        blank = (bcd_out_q[11:8] == 4'h0) && (bcd_out_q[7:4] == 4'h0);
      end
      2'd2: begin
        nib   = bcd_out_q[11:8];
        blank = (bcd_out_q[11:8] == 4'h0);
      end
      default: nib = bcd_out_q[3:0];
    endcase
    // Only completed results reach bcd_out_q, so the display never sees the
    // accumulator mid-conversion.
    if (bcd_valid_q) begin
      an_d  = 3'b001 << idx_q;
      seg_d = blank ? 7'h00 : seg_of(nib);
    end else begin
      an_d  = 3'b000;
      seg_d = 7'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 3'b000;
      seg_q <= 7'h00;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_counter_bcd_display.sv
module tb_counter_bcd_display;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_bcd_display_if bus ();

  counter_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  // Reference model: conversion timeline and display from plain arithmetic.
  int m_phase, m_val, m_last, m_disp, m_div, m_idx, m_an, m_seg;
  bit m_pending, m_valid, m_done, m_busy;

  typedef struct {
    int val;
    int exp_bcd;
    int s1;
    int s10;
    int s100;
  } vec_t;

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int  in_v;
    int  d;
    bit  blank;
    if (rst) begin
      m_phase = 0; m_last = 0; m_pending = 1; m_disp = 0; m_valid = 0;
      m_done = 0; m_busy = 0; m_div = 0; m_idx = 0; m_an = 0; m_seg = 0;
    end else begin
      in_v = int'(bus.counter_in);
      if (m_valid) begin
        case (m_idx)
          0: begin d = m_disp % 10;        blank = 0;              end
          1: begin d = (m_disp / 10) % 10; blank = (m_disp < 10);  end
          default: begin d = m_disp / 100; blank = (m_disp < 100); end
        endcase
        m_an  = 1 << m_idx;
        m_seg = blank ? 0 : seg_tab[d];
      end else begin
        m_an  = 0;
        m_seg = 0;
      end
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % 3;
      end else begin
        m_div++;
      end
      m_done = 0;
      if (m_phase == 0) begin
        if (m_pending || in_v != m_last) begin
          m_val = in_v; m_last = in_v; m_pending = 0; m_phase = 1; m_busy = 1;
        end
      end else if (m_phase == 9) begin
        m_disp = m_val; m_valid = 1; m_done = 1; m_busy = 0; m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy",      int'(bus.busy),      int'(m_busy));
    chk("done",      int'(bus.done),      int'(m_done));
    chk("bcd_valid", int'(bus.bcd_valid), int'(m_valid));
    chk("bcd_out",   int'(bus.bcd_out),   to_bcd(m_disp));
    chk("an",        int'(bus.an),        m_an);
    chk("seg",       int'(bus.seg),       m_seg);
    if (bus.done) $display("conv t=%0t bcd_out=%03h", $time, bus.bcd_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_busy"},  int'(bus.busy),      0);
    chk({nm, "_done"},  int'(bus.done),      0);
    chk({nm, "_valid"}, int'(bus.bcd_valid), 0);
    chk({nm, "_bcd"},   int'(bus.bcd_out),   0);
    chk({nm, "_an"},    int'(bus.an),        0);
    chk({nm, "_seg"},   int'(bus.seg),       0);
  endtask

  // Over one full scan period each digit must be lit SCAN_DIV cycles.
  task automatic observe(input string nm, input int s1, input int s10, input int s100);
    int n1, n2, n4;
    n1 = 0; n2 = 0; n4 = 0;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      step();
      case (bus.an)
        3'b001: begin n1++; chk({nm, "_ones_seg"}, int'(bus.seg), s1);   end
        3'b010: begin n2++; chk({nm, "_tens_seg"}, int'(bus.seg), s10);  end
        3'b100: begin n4++; chk({nm, "_hund_seg"}, int'(bus.seg), s100); end
        default: chk({nm, "_an_onehot"}, int'(bus.an), 1);
      endcase
    end
    chk({nm, "_ones_cycles"}, n1, SCAN_DIV);
    chk({nm, "_tens_cycles"}, n2, SCAN_DIV);
    chk({nm, "_hund_cycles"}, n4, SCAN_DIV);
  endtask

  initial begin
    vec_t vecs[10];
    int bc, dc, dn, first_bcd, second_bcd;

    vecs[0] = '{5,   'h005, 'h6D, 'h00, 'h00};
    vecs[1] = '{105, 'h105, 'h6D, 'h3F, 'h06};
    vecs[2] = '{255, 'h255, 'h6D, 'h6D, 'h5B};
    vecs[3] = '{0,   'h000, 'h3F, 'h00, 'h00};
    vecs[4] = '{9,   'h009, 'h6F, 'h00, 'h00};
    vecs[5] = '{10,  'h010, 'h3F, 'h06, 'h00};
    vecs[6] = '{100, 'h100, 'h3F, 'h3F, 'h06};
    vecs[7] = '{99,  'h099, 'h6F, 'h6F, 'h00};
    vecs[8] = '{200, 'h200, 'h3F, 'h3F, 'h5B};
    vecs[9] = '{47,  'h047, 'h07, 'h66, 'h00};

    // Reset with counter_in = 0
    rst = 1'b1;
    bus.counter_in = 8'd0;
    run(2);
    chk_reset_state("reset");
    rst = 1'b0;

    // Automatic first conversion after reset
    bc = 0; dc = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      bc += int'(bus.busy);
      dc += int'(bus.done);
    end
    chk("first_busy_cycles", bc, 9);
    chk("first_done_pulses", dc, 1);
    chk("first_bcd", int'(bus.bcd_out), 'h000);
    chk("first_valid", int'(bus.bcd_valid), 1);

    // 0 -> 255 latency: capture edge T0, result on T9, done only T9..T10
    bus.counter_in = 8'd255;
    step();
    chk("lat_busy_t0", int'(bus.busy), 1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("lat_no_early_done", int'(bus.done), 0);
      chk("lat_bcd_held", int'(bus.bcd_out), 'h000);
    end
    step();
    chk("lat_bcd_t9", int'(bus.bcd_out), 'h255);
    chk("lat_done_t9", int'(bus.done), 1);
    step();
    chk("lat_done_t10", int'(bus.done), 0);

    // Table of values: conversion result and per-digit display with blanking
    for (int v = 0; v < 10; v++) begin
      bus.counter_in = 8'(vecs[v].val);
      run(14);
      chk("vec_bcd", int'(bus.bcd_out), vecs[v].exp_bcd);
      chk("vec_valid", int'(bus.bcd_valid), 1);
      observe("vec", vecs[v].s1, vecs[v].s10, vecs[v].s100);
    end

    // 10 -> 11 -> 12 on consecutive cycles starting at a capture edge
    bus.counter_in = 8'd10;
    step();
    bus.counter_in = 8'd11;
    step();
    bus.counter_in = 8'd12;
    dn = 0; first_bcd = -1; second_bcd = -1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.done) begin
        dn++;
        if (dn == 1) first_bcd = int'(bus.bcd_out);
        if (dn == 2) second_bcd = int'(bus.bcd_out);
      end
    end
    chk("skip_done_pulses", dn, 2);
    chk("skip_first_bcd", first_bcd, 'h010);
    chk("skip_second_bcd", second_bcd, 'h012);
    chk("skip_final_bcd", int'(bus.bcd_out), 'h012);

    // Reset in the middle of converting 200
    bus.counter_in = 8'd77;
    run(14);
    chk("pre_abort_bcd", int'(bus.bcd_out), 'h077);
    bus.counter_in = 8'd200;
    step();
    run(3);
    rst = 1'b1;
    step();
    chk_reset_state("abort");
    rst = 1'b0;
    run(14);
    chk("abort_recover_bcd", int'(bus.bcd_out), 'h200);
    chk("abort_recover_valid", int'(bus.bcd_valid), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(5) == 0) bus.counter_in = 8'($urandom);
      rst = ($urandom_range(120) == 0);
      step();
    end
    rst = 1'b0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
